// File: rtl/multiplier_pkg.sv
// Shared constants and helpers for the sequential unsigned multiplier blocks.
`timescale 1ns/1ps
package multiplier_pkg;

  localparam int MULT_WIDTH_DEFAULT = 8;

  // Iteration counter width: wide enough to hold w-1, and never narrower than one bit.
  function automatic int count_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/multiplier_datapath_if.sv
// Strobe/operand bundle between multiplier_controller (master) and multiplier_datapath (slave).
`timescale 1ns/1ps
interface multiplier_datapath_if
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
);

  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               datapath_do_init;
  logic               datapath_do_shift;
  logic               counter_do_preset;
  logic               counter_do_decrement;
  logic               counter_is_zero;
  logic [2*WIDTH-1:0] product;

  modport master (
    output multiplicand,
    output multiplier,
    output datapath_do_init,
    output datapath_do_shift,
    output counter_do_preset,
    output counter_do_decrement,
    input  counter_is_zero,
    input  product
  );

  modport slave (
    input  multiplicand,
    input  multiplier,
    input  datapath_do_init,
    input  datapath_do_shift,
    input  counter_do_preset,
    input  counter_do_decrement,
    output counter_is_zero,
    output product
  );

endinterface

// File: rtl/multiplier_counter.sv
// Iteration counter: preset has priority over decrement, and decrement saturates at zero.
`timescale 1ns/1ps
module multiplier_counter
  import multiplier_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH_DEFAULT,
  parameter int PRESET = WIDTH - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic do_preset,
  input  logic do_decrement,
  output logic is_zero
);

  localparam int            CW       = count_width(WIDTH);
  localparam logic [CW-1:0] PRESET_C = CW'(PRESET);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

  logic [CW-1:0] count_r;

  // Counter register with preset priority and no wrap below zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= ZERO_C;
    end else if (do_preset) begin
      count_r <= PRESET_C;
    end else if (do_decrement && (count_r != ZERO_C)) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Decoded from the register only, so the controller's Mealy strobes cannot form a loop.
  assign is_zero = (count_r == ZERO_C);

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-and-add datapath for the sequential unsigned multiplier; WIDTH shifts after init yield the product.
`timescale 1ns/1ps
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  multiplier_datapath_if.slave bus
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [WIDTH:0]   sum_s;

  // Partial-product add; the extra bit keeps the carry that shifts into acc_hi's MSB.
  always_comb begin
    sum_s = {1'b0, acc_hi_r};
    if (acc_lo_r[0]) begin
      sum_s = {1'b0, acc_hi_r} + {1'b0, a_r};
    end else begin
      sum_s = {1'b0, acc_hi_r};
    end
  end

  // Operand/accumulator registers; init overrides a simultaneous shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r      <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
    end else if (bus.datapath_do_init) begin
      a_r      <= bus.multiplicand;
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= bus.multiplier;
    end else if (bus.datapath_do_shift) begin
      a_r      <= a_r;
      {acc_hi_r, acc_lo_r} <= {sum_s, acc_lo_r[WIDTH-1:1]};
    end else begin
      a_r      <= a_r;
      acc_hi_r <= acc_hi_r;
      acc_lo_r <= acc_lo_r;
    end
  end

  assign bus.product = {acc_hi_r, acc_lo_r};

  multiplier_counter #(
    .WIDTH  (WIDTH),
    .PRESET (WIDTH - 1)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .do_preset    (bus.counter_do_preset),
    .do_decrement (bus.counter_do_decrement),
    .is_zero      (bus.counter_is_zero)
  );

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_multiplier_datapath;
  import multiplier_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #200 clock = ~clock;

  multiplier_datapath_if #(.WIDTH(8)) mif ();
  multiplier_datapath_if #(.WIDTH(4)) mif4 ();

  multiplier_datapath #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif.slave)
  );

  multiplier_datapath #(.WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (mif4.slave)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Apply the current inputs at the next rising edge, then sample 100 units later.
  task automatic step();
    @(posedge clock);
    #100;
  endtask

  task automatic drive(input logic init, input logic shift, input logic preset, input logic dec);
    mif.datapath_do_init     = init;
    mif.datapath_do_shift    = shift;
    mif.counter_do_preset    = preset;
    mif.counter_do_decrement = dec;
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'h0000, mif.product}, {16'h0000, e});
    end
  endtask

  // Shifts with decrement, checking counter_is_zero after each decrement.
  task automatic shift_dec_phase(input string name);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      check($sformatf("%s_is_zero_dec%0d", name, i), {31'd0, mif.counter_is_zero},
            (i == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expected,
                      input string name);
    mif.multiplicand = a;
    mif.multiplier   = b;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(expected);
    step();
    shift_dec_phase(name);
    pop_check(name);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  expected: 16'h008F, name: "mul_13x11"};
    vecs[1] = '{a: 8'd255, b: 8'd255, expected: 16'hFE01, name: "mul_255x255"};
    vecs[2] = '{a: 8'd0,   b: 8'd200, expected: 16'h0000, name: "mul_0x200"};
    vecs[3] = '{a: 8'd1,   b: 8'd200, expected: 16'h00C8, name: "mul_1x200"};
    vecs[4] = '{a: 8'hA5,  b: 8'h3C,  expected: 16'h26AC, name: "mul_A5x3C"};

    reset = 1'b1;
    mif.multiplicand = 8'h00;
    mif.multiplier   = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    mif4.multiplicand = 4'h0;
    mif4.multiplier   = 4'h0;
    mif4.datapath_do_init     = 1'b0;
    mif4.datapath_do_shift    = 1'b0;
    mif4.counter_do_preset    = 1'b0;
    mif4.counter_do_decrement = 1'b0;
    #100;
    check("reset_product", {16'h0000, mif.product}, 32'h0000);
    check("reset_is_zero", {31'd0, mif.counter_is_zero}, 32'd1);
    reset = 1'b0;

    // Reset asserted mid-operation must clear without waiting for an edge.
    mif.multiplicand = 8'd13;
    mif.multiplier   = 8'd11;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    check("midrun_is_zero_before_reset", {31'd0, mif.counter_is_zero}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #50;
    reset = 1'b1;
    #10;
    check("async_reset_product", {16'h0000, mif.product}, 32'h0000);
    check("async_reset_is_zero", {31'd0, mif.counter_is_zero}, 32'd1);
    reset = 1'b0;
    #10;
    check("release_product", {16'h0000, mif.product}, 32'h0000);
    check("release_is_zero", {31'd0, mif.counter_is_zero}, 32'd1);
    step();

    for (int v = 0; v < 5; v++) begin
      run8(vecs[v].a, vecs[v].b, vecs[v].expected, vecs[v].name);
    end
    step();
    check("product_holds", {16'h0000, mif.product}, 32'h000026AC);

    // Restart: init mid-operation discards the partial product.
    mif.multiplicand = 8'd100;
    mif.multiplier   = 8'd3;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      step();
    end
    mif.multiplicand = 8'd6;
    mif.multiplier   = 8'd7;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(16'h002A);
    step();
    check("restart_loaded", {16'h0000, mif.product}, 32'h00000007);
    shift_dec_phase("restart");
    pop_check("restart_6x7");

    // Preset wins over decrement: exactly 7 decrements needed to reach zero again.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("preset_dec_is_zero", {31'd0, mif.counter_is_zero}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("count_down_%0d", i), {31'd0, mif.counter_is_zero},
            (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    check("dec_at_zero_holds", {31'd0, mif.counter_is_zero}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Init and shift together: init wins, operands load unshifted.
    mif.multiplicand = 8'h5A;
    mif.multiplier   = 8'hC3;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(16'h448E);
    step();
    check("init_shift_unshifted", {16'h0000, mif.product}, 32'h000000C3);
    shift_dec_phase("init_shift");
    pop_check("init_shift_5Ax_C3");

    // WIDTH=4 instance: 15*15 with 3 decrements and 4 shifts.
    mif4.multiplicand = 4'hF;
    mif4.multiplier   = 4'hF;
    mif4.datapath_do_init  = 1'b1;
    mif4.counter_do_preset = 1'b1;
    step();
    mif4.datapath_do_init     = 1'b0;
    mif4.counter_do_preset    = 1'b0;
    mif4.datapath_do_shift    = 1'b1;
    mif4.counter_do_decrement = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("w4_is_zero_dec%0d", i), {31'd0, mif4.counter_is_zero},
            (i == 3) ? 32'd1 : 32'd0);
    end
    mif4.counter_do_decrement = 1'b0;
    step();
    mif4.datapath_do_shift = 1'b0;
    check("w4_mul_15x15", {24'h000000, mif4.product}, 32'h000000E1);

    if (exp_q.size() != 0) begin
      check("scoreboard_drained", exp_q.size(), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
